beat_sequencer: RTL and testbench

- Drives the `currentBeat` index and 16-bit `qOut` pattern that the beat selector consumes.
- Holds the 16-step on/off pattern, edited by a key/switch interface.
- Advances a step counter at a programmable tempo while running.
- Sits between the user-input front end and the beat-select/audio path.

---
 rtl/seq_pkg.sv | 13 +
 rtl/tempo_divider.sv | 42 ++++
 rtl/beat_sequencer.sv | 103 ++++++++++
 tb/tb_beat_sequencer.sv | 384 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_pkg.sv
// Shared constants and FSM state type for the beat sequencer and its tempo divider.
package seq_pkg;

    localparam int STEPS      = 16;
    localparam int BEAT_W     = 4;
    localparam int MIN_PERIOD = 2;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/tempo_divider.sv
// Beat-period divider: latches the clamped tempo period at start and at every beat
// boundary, and flags the last cycle of each beat.
module tempo_divider
    import seq_pkg::*;
#(
    parameter int PERIOD_W = 26
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                load,
    input  logic                run,
    input  logic [PERIOD_W-1:0] tempo_period,
    output logic                boundary
);

    localparam logic [PERIOD_W-1:0] MIN_P = PERIOD_W'(MIN_PERIOD);
    localparam logic [PERIOD_W-1:0] ONE   = PERIOD_W'(1);

    logic [PERIOD_W-1:0] divider;
    logic [PERIOD_W-1:0] period;
    logic [PERIOD_W-1:0] period_next;

    // Periods of 0 or 1 would give a beat every cycle or never; both are clamped up.
    assign period_next = (tempo_period < MIN_P) ? MIN_P : tempo_period;
    assign boundary    = run && !load && (divider == period - ONE);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            divider <= '0;
            period  <= MIN_P;
        end else if (load || boundary) begin
            divider <= '0;
            period  <= period_next;
        end else if (run) begin
            divider <= divider + ONE;
        end else begin
            divider <= '0;
        end
    end

endmodule

// File: rtl/beat_sequencer.sv
// 16-step beat sequencer: run/stop FSM, beat counter and key-edited pattern register.
// Optional loop length via macro BEAT_SEQUENCER_LOOP_LEN_EN (adds loop_last input).
module beat_sequencer
    import seq_pkg::*;
#(
    parameter int PERIOD_W = 26
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                start,
    input  logic                stop,
    input  logic [PERIOD_W-1:0] tempo_period,
    input  logic [BEAT_W-1:0]   edit_step,
    input  logic                edit_key,
    input  logic                clear,
`ifdef BEAT_SEQUENCER_LOOP_LEN_EN
    input  logic [BEAT_W-1:0]   loop_last,
`endif
    output logic [BEAT_W-1:0]   current_beat,
    output logic [STEPS-1:0]    pattern,
    output logic                beat_tick,
    output logic                running
);

    state_t            state;
    logic              load;
    logic              run;
    logic              boundary;
    logic              edit_prev;
    logic [BEAT_W-1:0] next_beat;

    // stop outranks start, so a coincident pair never (re)starts playback.
    assign load = start && !stop;
    assign run  = (state == RUN) && !stop;

    tempo_divider #(
        .PERIOD_W(PERIOD_W)
    ) u_tempo_divider (
        .clock       (clock),
        .reset       (reset),
        .load        (load),
        .run         (run),
        .tempo_period(tempo_period),
        .boundary    (boundary)
    );

`ifdef BEAT_SEQUENCER_LOOP_LEN_EN
    logic [BEAT_W-1:0] loop_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            loop_q <= '1;
        end else if (load || boundary) begin
            loop_q <= loop_last;
        end
    end

    // >= rather than == so a beat already past a newly shortened loop wraps at once.
    assign next_beat = (current_beat >= loop_q) ? '0 : current_beat + BEAT_W'(1);
`else
    assign next_beat = current_beat + BEAT_W'(1);
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            current_beat <= '0;
            beat_tick    <= 1'b0;
            running      <= 1'b0;
        end else begin
            beat_tick <= 1'b0;
            if (stop) begin
                state        <= IDLE;
                current_beat <= '0;
                running      <= 1'b0;
            end else if (start) begin
                state        <= RUN;
                current_beat <= '0;
                running      <= 1'b1;
                beat_tick    <= 1'b1;
            end else if (boundary) begin
                current_beat <= next_beat;
                beat_tick    <= 1'b1;
            end
        end
    end

    // NOTE: the pattern is an ordinary register bank, so it takes the async reset like any flop.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pattern   <= '0;
            edit_prev <= 1'b0;
        end else begin
            edit_prev <= edit_key;
            if (clear) begin
                pattern <= '0;
            end else if (edit_key && !edit_prev) begin
                pattern[edit_step] <= ~pattern[edit_step];
            end
        end
    end

endmodule

// File: tb/tb_beat_sequencer.sv
// Self-checking bench for beat_sequencer: directed closed-form scenarios plus
// randomized traffic against a beat-level reference model.
module tb_beat_sequencer;

    localparam int PERIOD_W = 26;

    logic                clock = 1'b0;
    logic                reset;
    logic                start;
    logic                stop;
    logic [PERIOD_W-1:0] tempo_period;
    logic [3:0]          edit_step;
    logic                edit_key;
    logic                clear;
    logic [3:0]          current_beat;
    logic [15:0]         pattern;
    logic                beat_tick;
    logic                running;
`ifdef BEAT_SEQUENCER_LOOP_LEN_EN
    logic [3:0]          loop_last;
`endif

    int tests_run    = 0;
    int tests_failed = 0;

    // Reference model: beat number, cycles left in the current beat, pattern word.
    bit          m_running;
    bit          m_tick;
    int          m_beat;
    int          m_remain;
    int          m_loop;
    logic [15:0] m_pat;
    bit          m_prev;

    beat_sequencer #(
        .PERIOD_W(PERIOD_W)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .stop        (stop),
        .tempo_period(tempo_period),
        .edit_step   (edit_step),
        .edit_key    (edit_key),
        .clear       (clear),
`ifdef BEAT_SEQUENCER_LOOP_LEN_EN
        .loop_last   (loop_last),
`endif
        .current_beat(current_beat),
        .pattern     (pattern),
        .beat_tick   (beat_tick),
        .running     (running)
    );

    always #5 clock = ~clock;

    function automatic int clamp_period(input int p);
        return (p < 2) ? 2 : p;
    endfunction

    function automatic int cur_loop();
`ifdef BEAT_SEQUENCER_LOOP_LEN_EN
        return int'(loop_last);
`else
        return 15;
`endif
    endfunction

    task automatic model_reset();
        m_running = 0;
        m_tick    = 0;
        m_beat    = 0;
        m_remain  = 2;
        m_loop    = 15;
        m_pat     = '0;
        m_prev    = 0;
    endtask

    task automatic model_step();
        m_tick = 0;
        if (stop) begin
            m_running = 0;
            m_beat    = 0;
        end else if (start) begin
            m_running = 1;
            m_beat    = 0;
            m_tick    = 1;
            m_remain  = clamp_period(int'(tempo_period));
            m_loop    = cur_loop();
        end else if (m_running) begin
            m_remain--;
            if (m_remain == 0) begin
                m_beat   = (m_beat >= m_loop) ? 0 : m_beat + 1;
                m_tick   = 1;
                m_remain = clamp_period(int'(tempo_period));
                m_loop   = cur_loop();
            end
        end
        if (clear) m_pat = '0;
        else if (edit_key && !m_prev) m_pat[edit_step] = ~m_pat[edit_step];
        m_prev = edit_key;
    endtask

    // One clock: model follows the inputs seen at the edge; returns 1 ns after it.
    task automatic cycle();
        @(posedge clock);
        if (reset) model_reset();
        else model_step();
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        cycle();
        cycle();
        tests_run++;
        if (current_beat !== 4'd0 || pattern !== 16'h0000 || beat_tick !== 1'b0 || running !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset: beat=%0d pattern=%h tick=%b running=%b, expected 0/0000/0/0",
                     current_beat, pattern, beat_tick, running);
        end
        reset = 1'b0;
        cycle();
    endtask

    task automatic test_tempo4();
        tempo_period = 4;
        start = 1'b1;
        cycle();
        start = 1'b0;
        for (int k = 0; k <= 64; k++) begin
            tests_run++;
            if (beat_tick !== ((k % 4) == 0) || current_beat !== 4'((k / 4) % 16) || running !== 1'b1) begin
                tests_failed++;
                $display("FAIL tempo4 k=%0d: beat=%0d tick=%b running=%b, expected beat=%0d tick=%b running=1",
                         k, current_beat, beat_tick, running, (k / 4) % 16, (k % 4) == 0);
            end
            if (k < 64) cycle();
        end
    endtask

    task automatic test_min_period();
        for (int tp = 0; tp < 2; tp++) begin
            tempo_period = PERIOD_W'(tp);
            start = 1'b1;
            cycle();
            start = 1'b0;
            for (int k = 0; k <= 10; k++) begin
                tests_run++;
                if (beat_tick !== ((k % 2) == 0) || current_beat !== 4'(k / 2)) begin
                    tests_failed++;
                    $display("FAIL min_period tp=%0d k=%0d: beat=%0d tick=%b, expected beat=%0d tick=%b",
                             tp, k, current_beat, beat_tick, k / 2, (k % 2) == 0);
                end
                if (k < 10) cycle();
            end
        end
    endtask

    task automatic test_tempo_change();
        int  exp_beat;
        bit  exp_tick;
        tempo_period = 4;
        start = 1'b1;
        cycle();
        start = 1'b0;
        for (int k = 0; k <= 20; k++) begin
            exp_tick = (k == 0) || (k == 4) || (k == 12) || (k == 20);
            exp_beat = (k < 4) ? 0 : (k < 12) ? 1 : (k < 20) ? 2 : 3;
            tests_run++;
            if (beat_tick !== exp_tick || current_beat !== 4'(exp_beat)) begin
                tests_failed++;
                $display("FAIL tempo_change k=%0d: beat=%0d tick=%b, expected beat=%0d tick=%b",
                         k, current_beat, beat_tick, exp_beat, exp_tick);
            end
            if (k == 2) tempo_period = 8;
            if (k < 20) cycle();
        end
        stop = 1'b1;
        cycle();
        stop = 1'b0;
    endtask

    task automatic test_edit();
        edit_step = 4'd5;
        edit_key  = 1'b1;
        for (int k = 0; k < 10; k++) begin
            cycle();
            tests_run++;
            if (pattern !== 16'h0020) begin
                tests_failed++;
                $display("FAIL edit_hold k=%0d: pattern=%h, expected 0020", k, pattern);
            end
        end
        edit_key = 1'b0;
        cycle();
        edit_key = 1'b1;
        cycle();
        tests_run++;
        if (pattern !== 16'h0000) begin
            tests_failed++;
            $display("FAIL edit_second_press: pattern=%h, expected 0000", pattern);
        end
        edit_key = 1'b0;
        cycle();
        clear    = 1'b1;
        edit_key = 1'b1;
        cycle();
        cycle();
        clear = 1'b0;
        cycle();
        tests_run++;
        if (pattern !== 16'h0000) begin
            tests_failed++;
            $display("FAIL edit_clear: pattern=%h, expected 0000", pattern);
        end
        edit_key = 1'b0;
        cycle();
    endtask

    task automatic test_stop_start();
        tempo_period = 2;
        start = 1'b1;
        cycle();
        start = 1'b0;
        cycle();
        cycle();
        start = 1'b1;
        stop  = 1'b1;
        cycle();
        start = 1'b0;
        stop  = 1'b0;
        tests_run++;
        if (running !== 1'b0 || current_beat !== 4'd0 || beat_tick !== 1'b0) begin
            tests_failed++;
            $display("FAIL start_stop_same_cycle: running=%b beat=%0d tick=%b, expected 0/0/0",
                     running, current_beat, beat_tick);
        end
        start = 1'b1;
        cycle();
        start = 1'b0;
        for (int k = 0; k < 18; k++) cycle();
        tests_run++;
        if (current_beat !== 4'd9) begin
            tests_failed++;
            $display("FAIL reach_beat9: beat=%0d, expected 9", current_beat);
        end
        start = 1'b1;
        cycle();
        start = 1'b0;
        tests_run++;
        if (current_beat !== 4'd0 || beat_tick !== 1'b1 || running !== 1'b1) begin
            tests_failed++;
            $display("FAIL restart_at_beat9: beat=%0d tick=%b running=%b, expected 0/1/1",
                     current_beat, beat_tick, running);
        end
        stop = 1'b1;
        cycle();
        stop = 1'b0;
    endtask

    task automatic test_async_reset();
        logic [15:0] target;
        target = 16'hA5A5;
        for (int i = 0; i < 16; i++) begin
            if (target[i]) begin
                edit_step = 4'(i);
                edit_key  = 1'b1;
                cycle();
                edit_key = 1'b0;
                cycle();
            end
        end
        tests_run++;
        if (pattern !== 16'hA5A5) begin
            tests_failed++;
            $display("FAIL build_pattern: pattern=%h, expected a5a5", pattern);
        end
        tempo_period = 2;
        start = 1'b1;
        cycle();
        start = 1'b0;
        for (int k = 0; k < 14; k++) cycle();
        tests_run++;
        if (current_beat !== 4'd7 || running !== 1'b1) begin
            tests_failed++;
            $display("FAIL reach_beat7: beat=%0d running=%b, expected 7/1", current_beat, running);
        end
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        tests_run++;
        if (current_beat !== 4'd0 || pattern !== 16'h0000 || running !== 1'b0 || beat_tick !== 1'b0) begin
            tests_failed++;
            $display("FAIL async_reset: beat=%0d pattern=%h running=%b tick=%b, expected 0/0000/0/0",
                     current_beat, pattern, running, beat_tick);
        end
        cycle();
        reset = 1'b0;
        cycle();
    endtask

`ifdef BEAT_SEQUENCER_LOOP_LEN_EN
    task automatic test_loop();
        int exp_beat;
        loop_last    = 4'd3;
        tempo_period = 2;
        start = 1'b1;
        cycle();
        start = 1'b0;
        for (int k = 0; k <= 14; k++) begin
            exp_beat = (k < 8) ? (k / 2) % 4 : ((k - 8) / 2) % 2;
            tests_run++;
            if (current_beat !== 4'(exp_beat) || beat_tick !== ((k % 2) == 0)) begin
                tests_failed++;
                $display("FAIL loop k=%0d: beat=%0d tick=%b, expected beat=%0d tick=%b",
                         k, current_beat, beat_tick, exp_beat, (k % 2) == 0);
            end
            if (k == 6) loop_last = 4'd1;
            if (k < 14) cycle();
        end
        loop_last = 4'd15;
        stop = 1'b1;
        cycle();
        stop = 1'b0;
    endtask
`endif

    task automatic test_random();
        for (int n = 0; n < 1500; n++) begin
            start        = ($urandom_range(0, 19) == 0);
            stop         = ($urandom_range(0, 39) == 0);
            clear        = ($urandom_range(0, 24) == 0);
            edit_key     = $urandom_range(0, 1);
            edit_step    = 4'($urandom_range(0, 15));
            tempo_period = PERIOD_W'($urandom_range(0, 5));
`ifdef BEAT_SEQUENCER_LOOP_LEN_EN
            if ($urandom_range(0, 15) == 0) loop_last = 4'($urandom_range(0, 15));
`endif
            cycle();
            tests_run++;
            if (current_beat !== 4'(m_beat) || beat_tick !== m_tick || running !== m_running || pattern !== m_pat) begin
                tests_failed++;
                $display("FAIL random n=%0d: beat=%0d tick=%b run=%b pat=%h, expected beat=%0d tick=%b run=%b pat=%h",
                         n, current_beat, beat_tick, running, pattern, m_beat, m_tick, m_running, m_pat);
            end
        end
        start    = 1'b0;
        stop     = 1'b0;
        clear    = 1'b0;
        edit_key = 1'b0;
    endtask

    initial begin
        reset        = 1'b1;
        start        = 1'b0;
        stop         = 1'b0;
        tempo_period = 4;
        edit_step    = 4'd0;
        edit_key     = 1'b0;
        clear        = 1'b0;
`ifdef BEAT_SEQUENCER_LOOP_LEN_EN
        loop_last    = 4'd15;
`endif
        model_reset();

        test_reset();
        test_tempo4();
        test_min_period();
        test_tempo_change();
        test_edit();
        test_stop_start();
        test_async_reset();
`ifdef BEAT_SEQUENCER_LOOP_LEN_EN
        test_loop();
`endif
        test_random();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
